// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out sequencer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Bit counter width for a given word width (at least one bit).
  function automatic int unsigned piso_cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_seq_ctrl.sv
// Parallel word to one-bit stream sequencer with valid/ready on both sides.
module piso_seq_ctrl
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

  localparam int unsigned CW = piso_cnt_w(WIDTH);

  piso_state_t      r_state, w_state_d;
  logic [WIDTH-1:0] r_sreg, w_sreg_d;
  logic [CW-1:0]    r_cnt, w_cnt_d;
  logic             w_last;
  logic             w_shift;
  logic [WIDTH-1:0] w_sreg_shifted;

  assign w_last  = (r_cnt == '0);
  assign w_shift = (r_state == SHIFT);

  // Move the register one place toward the output end, zero-filling behind.
  assign w_sreg_shifted = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};

  // State, shift register and bit counter; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_sreg  <= w_sreg_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Next-state: load on handshake, shift on accepted beat, reload or idle after last.
  always_comb begin
    w_state_d = r_state;
    w_sreg_d  = r_sreg;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_sreg_d  = in_data;
          w_cnt_d   = CW'(WIDTH - 1);
          w_state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          if (!w_last) begin
            w_sreg_d = w_sreg_shifted;
            w_cnt_d  = r_cnt - CW'(1);
          end else if (in_valid) begin
            // Back-to-back word: no idle gap in the stream.
            w_sreg_d = in_data;
            w_cnt_d  = CW'(WIDTH - 1);
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Outputs come straight from state; only ser_ready reaches in_ready combinationally.
  always_comb begin
    in_ready  = !rst && ((r_state == IDLE) || (w_shift && w_last && ser_ready));
    ser_valid = !rst && w_shift;
    busy      = !rst && w_shift;
    ser_last  = !rst && w_shift && w_last;
    ser_out   = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
  end

endmodule

// File: doc/piso_seq_ctrl.md
Name: piso_seq_ctrl

Overview:
Sequencer that takes parallel words over a valid/ready handshake and serialises them onto a one-bit stream with per-bit valid/ready flow control. It holds the shift register, the bit counter and the control FSM. It sits between a parallel register stage (PIPO-style producer) and a serial consumer.

Parameters:
WIDTH, 4, word width in bits; legal range WIDTH >= 2.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  parallel word present on in_data.
in_data  input  WIDTH  parallel word to serialise.
in_ready  output  1  block accepts a word this cycle.
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out is valid.
ser_last  output  1  current bit is the final bit of the word.
ser_ready  input  1  consumer accepts the bit this cycle.
busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state=IDLE, sreg=0, cnt=0. Outputs while rst=1: ser_out=0, ser_valid=0, ser_last=0, busy=0, in_ready=0.
- Reset mid-frame: takes effect immediately and asynchronously. The partial word is discarded, and no further bits of it appear after reset is released.
- Internal state: sreg[WIDTH-1:0]; cnt of width $clog2(WIDTH); 2-state FSM with states IDLE and SHIFT.
- IDLE:
  - in_ready=1 and ser_valid=0.
  - On in_valid&in_ready: sreg<=in_data, cnt<=WIDTH-1, state<=SHIFT.
- SHIFT:
  - ser_valid=1 and busy=1.
  - ser_out=sreg[WIDTH-1] when MSB_FIRST=1, else sreg[0]. ser_out is driven directly from the register, with no combinational path from in_data.
  - ser_last=1 exactly when cnt==0.
- Beat accept: ser_valid&ser_ready.
  - Not last: shift sreg by one toward the output end, zero-filling the vacated bit; cnt<=cnt-1.
  - Last (cnt==0) with in_valid=1: back-to-back load, sreg<=in_data, cnt<=WIDTH-1, stay in SHIFT. The stream has no gap.
  - Last with in_valid=0: state<=IDLE; sreg is left unchanged.
- in_ready = (state==IDLE) | (state==SHIFT & cnt==0 & ser_ready), gated low while rst=1. This is the only combinational input-to-output path, ser_ready to in_ready.
- Backpressure: while ser_valid=1 and ser_ready=0, hold ser_out, ser_last, sreg and cnt stable. No bit is lost or duplicated.
- in_data and in_valid are ignored whenever in_ready=0.
- Latency: handshake in cycle T puts the first bit valid in cycle T+1. With ser_ready held high, the word occupies cycles T+1..T+WIDTH, and ser_last is set in cycle T+WIDTH.
- Throughput: one bit per cycle. Words stream continuously when in_valid is held high.

Decomposition:
- Package piso_pkg holds:
  - state typedef enum {IDLE, SHIFT};
  - localparam function for counter width, CW = $clog2(WIDTH).
- Single module, no sub-module. The shift/count datapath is too small to justify splitting.

Test Plan:
- Reset: hold rst=1 with arbitrary inputs. Required: ser_valid=0, ser_out=0, ser_last=0, busy=0, in_ready=0. After release: in_ready=1.
- Basic serialise (WIDTH=4, MSB_FIRST=1, ser_ready=1): load 4'b1011 at cycle T. Required: ser_out=1,0,1,1 on cycles T+1..T+4; ser_last only at T+4; busy=0 and in_ready=1 at T+5.
- Backpressure: load 4'b1011 and drop ser_ready for 3 cycles while bit 2 (value 0) is presented. Required: ser_out held at 0 and ser_valid held at 1 for those cycles. The full sequence 1,0,1,1 still arrives exactly once.
- Back-to-back: keep in_valid=1 with 4'b1100 then 4'b0011. Required:
  - 8 contiguous valid bits 1,1,0,0,0,0,1,1;
  - the second handshake coincides with the first ser_last;
  - ser_last is set on bits 4 and 8.
- Mid-frame reset: load 4'b1110 and assert rst after 2 bits. Required: ser_valid falls in the same cycle. After release, loading 4'b0101 yields exactly 0,1,0,1 with no residue.
- LSB-first (MSB_FIRST=0): load 4'b1011. Required: ser_out=1,1,0,1, with ser_last on the fourth bit.
